// File: rtl/dac_axis_buffer_pkg.sv
// rtl/dac_axis_buffer_pkg.sv - shared DAC buffer types, counter width and helpers
package dac_axis_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } dac_state_t;

    localparam int COUNT_WIDTH = 16;

    // Error counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/dac_axis_buffer_fifo.sv
// rtl/dac_axis_buffer_fifo.sv - circular sample store with wrap-bit pointers and level
module dac_sample_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           next_head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_next;

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};

    // Head after this cycle's pop; when that leaves the store empty the incoming word is the head.
    assign next_head = (level == {{AW{1'b0}}, pop}) ? wr_data : mem[rd_ptr_next[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
            rd_ptr <= rd_ptr_next;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_axis_buffer.sv
// rtl/dac_axis_buffer.sv - priming elastic buffer between DDS source and RFDC DAC stream
module dac_axis_buffer
    import dac_axis_buffer_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int DEPTH           = 8,
    parameter int PRIME_LEVEL     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         clear_error,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                         m00_axis_tvalid,
    input  logic                         m00_axis_tready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow_error,
    output logic                         underflow_error,
    output logic [COUNT_WIDTH-1:0]       overflow_count,
    output logic [COUNT_WIDTH-1:0]       underflow_count
);
    localparam int LW = $clog2(DEPTH) + 1;

    dac_state_t                 state, state_next;
    logic                       full, empty, push, pop;
    logic                       overflow_event, underflow_event;
    logic [AXIS_DATA_WIDTH-1:0] next_head;
    logic [LW-1:0]              next_level;

    // The source cannot stall, so a full buffer without a pop drops the sample.
    assign pop             = m00_axis_tvalid && m00_axis_tready;
    assign push            = s_axis_tvalid && (!full || pop) && !flush;
    assign overflow_event  = s_axis_tvalid && full && !pop && !flush;
    assign underflow_event = (state == RUN) && m00_axis_tready && empty;
    assign next_level      = level + LW'(push) - LW'(pop);

    dac_sample_fifo #(
        .WIDTH (AXIS_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_data   (s_axis_tdata),
        .next_head (next_head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (push) state_next = PRIME;
                PRIME:   if (level >= LW'(PRIME_LEVEL)) state_next = RUN;
                RUN:     if (underflow_event) state_next = PRIME;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output register mirrors the buffer head; only shown while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if ((state_next == RUN) && (next_level != '0)) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= next_head;
        end else begin
            m00_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
            overflow_count  <= '0;
            underflow_count <= '0;
        end else begin
            if (overflow_event) begin
                overflow_error <= 1'b1;
                overflow_count <= clear_error ? COUNT_WIDTH'(1) : sat_inc(overflow_count);
            end else if (clear_error) begin
                overflow_error <= 1'b0;
                overflow_count <= '0;
            end
            if (underflow_event) begin
                underflow_error <= 1'b1;
                underflow_count <= clear_error ? COUNT_WIDTH'(1) : sat_inc(underflow_count);
            end else if (clear_error) begin
                underflow_error <= 1'b0;
                underflow_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dac_axis_buffer.sv
// tb/tb_dac_axis_buffer.sv - scoreboard bench for dac_axis_buffer
module tb_dac_axis_buffer;
    import dac_axis_buffer_pkg::*;

    localparam int W     = 256;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush = 1'b0;
    logic                   clear_error = 1'b0;
    logic [W-1:0]           s_axis_tdata = '0;
    logic                   s_axis_tvalid = 1'b0;
    logic [W-1:0]           m00_axis_tdata;
    logic                   m00_axis_tvalid;
    logic                   m00_axis_tready = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow_error, underflow_error;
    logic [15:0]            overflow_count, underflow_count;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] exp_q[$];

    dac_axis_buffer #(
        .AXIS_DATA_WIDTH (W),
        .DEPTH           (DEPTH),
        .PRIME_LEVEL     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .clear_error     (clear_error),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .level           (level),
        .overflow_error  (overflow_error),
        .underflow_error (underflow_error),
        .overflow_count  (overflow_count),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v, input bit accepted);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = W'(v);
        if (accepted) exp_q.push_back(W'(v));
        tick();
    endtask

    // Monitor: every output handshake must match the next expected sample.
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!reset && m00_axis_tvalid && m00_axis_tready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_extra: got %0h expected no output", m00_axis_tdata);
            end else begin
                exp = exp_q.pop_front();
                check("out_data", m00_axis_tdata, exp);
            end
        end
    end

    initial begin
        repeat (2) tick();
        check("rst_tvalid", m00_axis_tvalid, 0);
        check("rst_tdata", m00_axis_tdata, 0);
        check("rst_level", level, 0);
        check("rst_ovf_err", overflow_error, 0);
        check("rst_unf_err", underflow_error, 0);
        check("rst_ovf_cnt", overflow_count, 0);
        check("rst_unf_cnt", underflow_count, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        tick();

        // Priming, then a steady stream with tready=1.
        m00_axis_tready = 1'b1;
        for (int v = 1; v <= 4; v++) wr(v, 1'b1);
        check("prime_level", level, 4);
        check("prime_tvalid_low", m00_axis_tvalid, 0);
        wr(5, 1'b1);
        check("prime_tvalid_rise", m00_axis_tvalid, 1);
        check("prime_first_data", m00_axis_tdata, 1);
        for (int v = 6; v <= 10; v++) wr(v, 1'b1);
        check("stream_level", level, 5);
        check("stream_data", m00_axis_tdata, 6);

        // Backpressure: 10 stalled cycles, 6 inputs of which the last 3 overflow.
        m00_axis_tready = 1'b0;
        for (int v = 11; v <= 16; v++) begin
            wr(v, v <= 13);
            check("bp_hold", m00_axis_tdata, 6);
        end
        s_axis_tvalid = 1'b0;
        repeat (4) begin
            tick();
            check("bp_hold", m00_axis_tdata, 6);
        end
        check("bp_level", level, 8);
        check("bp_ovf_cnt", overflow_count, 3);
        check("bp_ovf_err", overflow_error, 1);
        check("bp_tvalid", m00_axis_tvalid, 1);

        // Full buffer with simultaneous write and pop.
        m00_axis_tready = 1'b1;
        for (int v = 17; v <= 19; v++) begin
            wr(v, 1'b1);
            check("full_wr_pop_level", level, 8);
        end
        check("full_wr_pop_ovf", overflow_count, 3);

        // Underflow: drain 8, then one cycle of RUN with empty buffer.
        s_axis_tvalid = 1'b0;
        repeat (8) tick();
        check("drain_level", level, 0);
        check("drain_tvalid", m00_axis_tvalid, 0);
        check("drain_unf_cnt", underflow_count, 0);
        tick();
        check("unf_cnt", underflow_count, 1);
        check("unf_err", underflow_error, 1);
        check("unf_tvalid", m00_axis_tvalid, 0);
        check("unf_state", dut.state, PRIME);
        check("scoreboard_drained", exp_q.size(), 0);
        for (int v = 20; v <= 23; v++) wr(v, 1'b1);
        check("reprime_tvalid_low", m00_axis_tvalid, 0);
        check("reprime_level", level, 4);
        s_axis_tvalid = 1'b0;
        tick();
        m00_axis_tready = 1'b0;
        check("reprime_tvalid", m00_axis_tvalid, 1);
        check("reprime_data", m00_axis_tdata, 20);

        // Flush mid-stream with a same-cycle write that must be discarded.
        wr(24, 1'b1);
        check("pre_flush_level", level, 5);
        check("pre_flush_tvalid", m00_axis_tvalid, 1);
        flush = 1'b1;
        wr(25, 1'b0);
        flush = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        check("flush_level", level, 0);
        check("flush_tvalid", m00_axis_tvalid, 0);
        check("flush_state", dut.state, IDLE);
        check("flush_ovf_cnt", overflow_count, 3);
        check("flush_unf_cnt", underflow_count, 1);
        tick();
        check("flush_discard_level", level, 0);

        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("clr_ovf_err", overflow_error, 0);
        check("clr_unf_err", underflow_error, 0);
        check("clr_ovf_cnt", overflow_count, 0);
        check("clr_unf_cnt", underflow_count, 0);

        // Asynchronous reset while running.
        for (int v = 30; v <= 33; v++) wr(v, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        check("pre_rst_tvalid", m00_axis_tvalid, 1);
        check("pre_rst_data", m00_axis_tdata, 30);
        check("pre_rst_state", dut.state, RUN);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tvalid", m00_axis_tvalid, 0);
        check("async_rst_tdata", m00_axis_tdata, 0);
        check("async_rst_level", level, 0);
        check("async_rst_state", dut.state, IDLE);
        tick();
        reset = 1'b0;
        tick();

        // Saturation: 8 accepted writes then 70000 overflows.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = W'(40);
        repeat (70008) tick();
        check("sat_ovf_cnt", overflow_count, 16'hFFFF);
        check("sat_ovf_err", overflow_error, 1);
        check("sat_level", level, 8);
        s_axis_tvalid = 1'b0;
        clear_error   = 1'b1;
        tick();
        check("sat_clr_cnt", overflow_count, 0);
        check("sat_clr_err", overflow_error, 0);
        s_axis_tvalid = 1'b1;
        tick();
        check("clr_vs_event_cnt", overflow_count, 1);
        check("clr_vs_event_err", overflow_error, 1);
        clear_error   = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dac_axis_buffer.md
DAC_AXIS_BUFFER -- requirements
Module: dac_axis_buffer

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 256; width of one RFDC sample word.
REQ-002 SHALL have parameter DEPTH, default 8; storage words, power of two, at least 4.
REQ-003 SHALL have parameter PRIME_LEVEL, default 4; fill level that releases the output, range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit; sole clock (rtio_clk domain).
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1 bit; synchronous discard of all buffered samples.
REQ-007 SHALL have port clear_error, input, 1 bit; synchronous clear of the sticky flags and counters.
REQ-008 SHALL have port s_axis_tdata, input, AXIS_DATA_WIDTH; sample from the DDS generator.
REQ-009 SHALL have port s_axis_tvalid, input, 1 bit; sample valid. There is no s_axis_tready because the source cannot stall.
REQ-010 SHALL have port m00_axis_tdata, output, AXIS_DATA_WIDTH; sample to the RFDC DAC.
REQ-011 SHALL have port m00_axis_tvalid, output, 1 bit.
REQ-012 SHALL have port m00_axis_tready, input, 1 bit.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1 bits; current occupancy.
REQ-014 SHALL have port overflow_error, output, 1 bit; sticky.
REQ-015 SHALL have port underflow_error, output, 1 bit; sticky.
REQ-016 SHALL have port overflow_count, output, 16 bits; saturating.
REQ-017 SHALL have port underflow_count, output, 16 bits; saturating.

Function
REQ-018 SHALL store samples in a circular buffer with DEPTH entries, using read and write pointers one bit wider than the address; the buffer is full when the MSBs differ and the addresses are equal.
REQ-019 SHALL write on every cycle with s_axis_tvalid=1 when not full, or when full with a simultaneous pop; the pop is evaluated before the write.
REQ-020 SHALL discard s_axis_tdata when s_axis_tvalid=1, the buffer is full and there is no pop; on that cycle it sets overflow_error and increments overflow_count.
REQ-021 SHALL pop when m00_axis_tvalid and m00_axis_tready are both 1.
REQ-022 SHALL register m00_axis_tdata and m00_axis_tvalid; a sample written into an empty buffer in RUN appears on the output one cycle later.
REQ-023 SHALL hold m00_axis_tdata and m00_axis_tvalid stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-024 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-025 SHALL move IDLE->PRIME on the first accepted write.
REQ-026 SHALL move PRIME->RUN when level >= PRIME_LEVEL.
REQ-027 SHALL move RUN->PRIME on underflow.
REQ-028 SHALL move any state ->IDLE on flush.
REQ-029 SHALL hold m00_axis_tvalid=0 in IDLE and PRIME.
REQ-030 SHALL treat underflow as RUN with m00_axis_tready=1 and the buffer empty; it sets underflow_error, increments underflow_count and deasserts m00_axis_tvalid on the next cycle.
REQ-031 SHALL saturate both counters at 16'hFFFF, with no wrap.
REQ-032 SHALL on flush zero the pointers and level and clear m00_axis_tvalid; any same-cycle write is discarded and not counted.
REQ-033 SHALL on clear_error zero the flags and counters; an error event on the same cycle wins and leaves the flag at 1 and the count at 1.
REQ-034 SHALL update level as +1 for a write only, -1 for a pop only, and unchanged for both or neither.

Reset
REQ-035 SHALL on reset asynchronously drive FSM=IDLE, pointers=0, level=0, m00_axis_tvalid=0, m00_axis_tdata=0, both flags=0 and both counters=0.
REQ-036 SHALL leave storage RAM contents uninitialised.
REQ-037 SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-038 SHALL take the FSM state enum (IDLE/PRIME/RUN) and the 16-bit counter width constant from the shared DAC package.
REQ-039 SHALL place the circular buffer in one sub-module, dac_sample_fifo: storage, pointers, full, empty and level. The FSM, output register and error logic SHALL stay in the top module.

Verification
REQ-040 SHALL verify priming: after reset, 4 writes of 1..4 -> m00_axis_tvalid rises the cycle after level=4; data out is 1,2,3,4 in order with tready=1.
REQ-041 SHALL verify backpressure: m00_axis_tready=0 for 10 cycles with continuous input -> output holds the value present when it stalled. Level reaches 8, then the next 3 inputs are dropped, overflow_count=3 and overflow_error=1.
REQ-042 SHALL verify underflow: in RUN with tready=1, input stops -> the cycle after the last sample is consumed, underflow_count=1 and tvalid=0. The FSM is in PRIME, and tvalid returns after 4 new writes.
REQ-043 SHALL verify simultaneous write and pop when full: level stays 8 and no overflow is counted.
REQ-044 SHALL verify flush mid-stream: flush while level=5 and tvalid=1 -> the next cycle shows level=0, tvalid=0 and FSM=IDLE, and the counters are unchanged.
REQ-045 SHALL verify reset mid-stream and saturation: reset while RUN -> all outputs are 0 immediately (asynchronously). Forcing 70000 overflows -> overflow_count=16'hFFFF, and clear_error then sets it to 0.
